// File: rtl/crc5_codeword_tx.sv
// crc5_codeword_tx: assembles {msg, crc, pad} into a 12-bit codeword and
// serializes it MSB-first, 2 bits per beat, over a valid/ready stream.
// Optional self-check (macro CRC5_SELFCHECK_EN) recomputes the CRC-5
// (g(x) = x^5 + x^3 + x + 1) over the sent message bits and raises crc_err
// on the last beat if it disagrees with the supplied remainder.
module crc5_codeword_tx #(
    parameter logic PAD_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] msg_in,
    input  logic [4:0] crc_in,
    input  logic       load_valid,
    output logic       load_ready,
    output logic [1:0] ser_out,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_last,
    output logic       crc_err
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [5:0]  msg_q, msg_d;
    logic [4:0]  crc_q, crc_d;
    logic [1:0]  ser_out_q, ser_out_d;
    logic        ser_last_q, ser_last_d;
    logic        accept;
    logic        beat_fire;

    // Two codeword bits carried by a given beat index.
    function automatic logic [1:0] beat_bits(input logic [2:0] b,
                                             input logic [5:0] m,
                                             input logic [4:0] c);
        logic [1:0] r;
        case (b)
            3'd0:    r = m[5:4];
            3'd1:    r = m[3:2];
            3'd2:    r = m[1:0];
            3'd3:    r = c[4:3];
            3'd4:    r = c[2:1];
            3'd5:    r = {c[0], PAD_VAL};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

`ifdef CRC5_SELFCHECK_EN
    logic [4:0] lfsr_q, lfsr_d;
    logic       crc_err_q, crc_err_d;

    // One MSB-first division step of the remainder by g(x).
    function automatic logic [4:0] lfsr_step(input logic [4:0] r, input logic b);
        logic fb;
        fb = r[4] ^ b;
        return {r[3:0], 1'b0} ^ (fb ? 5'b01011 : 5'b00000);
    endfunction
`endif

    assign accept    = load_valid & load_ready;
    assign beat_fire = (state_q == SEND) & ser_ready;

    // Next-state: load takes priority (it can coincide with the last-beat handshake).
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        msg_d      = msg_q;
        crc_d      = crc_q;
`ifdef CRC5_SELFCHECK_EN
        lfsr_d     = lfsr_q;
`endif
        if (accept) begin
            state_d = SEND;
            beat_d  = 3'd0;
            msg_d   = msg_in;
            crc_d   = crc_in;
`ifdef CRC5_SELFCHECK_EN
            lfsr_d  = '0;
`endif
        end else if (beat_fire) begin
            if (beat_q == 3'd5) begin
                state_d = IDLE;
                beat_d  = 3'd0;
            end else begin
                beat_d  = beat_q + 3'd1;
            end
`ifdef CRC5_SELFCHECK_EN
            // The beat just accepted is ser_out_q; fold its two message bits in.
            if (beat_q < 3'd3)
                lfsr_d = lfsr_step(lfsr_step(lfsr_q, ser_out_q[1]), ser_out_q[0]);
`endif
        end
        ser_out_d  = (state_d == SEND) ? beat_bits(beat_d, msg_d, crc_d) : 2'b00;
        ser_last_d = (state_d == SEND) & (beat_d == 3'd5);
`ifdef CRC5_SELFCHECK_EN
        crc_err_d  = ser_last_d & (lfsr_d != crc_d);
`endif
    end

    // State and registered outputs; synchronous reset aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            msg_q      <= '0;
            crc_q      <= '0;
            ser_out_q  <= '0;
            ser_last_q <= 1'b0;
`ifdef CRC5_SELFCHECK_EN
            lfsr_q     <= '0;
            crc_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            msg_q      <= msg_d;
            crc_q      <= crc_d;
            ser_out_q  <= ser_out_d;
            ser_last_q <= ser_last_d;
`ifdef CRC5_SELFCHECK_EN
            lfsr_q     <= lfsr_d;
            crc_err_q  <= crc_err_d;
`endif
        end
    end

    // ser_last_q is only ever set while in SEND, so it stands in for the state term.
    assign load_ready = (state_q == IDLE) | (ser_last_q & ser_ready);
    assign ser_out    = ser_out_q;
    assign ser_valid  = (state_q == SEND);
    assign ser_last   = ser_last_q;
`ifdef CRC5_SELFCHECK_EN
    assign crc_err    = crc_err_q;
`else
    assign crc_err    = 1'b0;
`endif

endmodule
